mem_port_arbiter: RTL

//   Shares one single-ported memory between instruction fetch (F) and data access (D).

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, fixed-latency memory between instruction fetch and data access.
// Data normally wins; a streak counter forces a fetch grant after a run of contested data grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_done,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mux_sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [3:0] LastBusy  = 4'(LATENCY);
  localparam logic [3:0] StarveLim = 4'(STARVE_LIM);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [3:0]        streak_q;
  logic              f_done_q, d_done_q;
  logic [DATA_W-1:0] f_rdata_q, d_rdata_q;
  logic              mux_sel_q, mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic any_req;
  logic grant_d;

  assign any_req = f_req | d_req;
  // Data wins unless fetch is also waiting and has already lost StarveLim times in a row.
  assign grant_d = d_req & ~(f_req & (streak_q == StarveLim));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      streak_q    <= '0;
      f_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mux_sel_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q <= 1'b0;
      f_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q    <= StBusy;
            cnt_q      <= '0;
            mem_en_q   <= 1'b1;
            mux_sel_q  <= grant_d;
            mem_addr_q <= grant_d ? d_addr : f_addr;
            mem_we_q   <= grant_d & d_we;
            if (grant_d && d_we) begin
              mem_wdata_q <= d_wdata;
            end
            if (grant_d && f_req) begin
              streak_q <= (streak_q == StarveLim) ? streak_q : streak_q + 4'd1;
            end else begin
              streak_q <= '0;
            end
          end
        end
        StBusy: begin
          if (cnt_q == LastBusy) begin
            state_q <= StDone;
            if (mux_sel_q) begin
              d_done_q <= 1'b1;
              if (!mem_we_q) begin
                d_rdata_q <= mem_rdata;
              end
            end else begin
              f_done_q  <= 1'b1;
              f_rdata_q <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign f_done    = f_done_q;
  assign d_done    = d_done_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mux_sel   = mux_sel_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
